// File: rtl/comp_pkg.sv
// rtl/comp_pkg.sv - shared types and result codes for the sequential comparator
package comp_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  // Result codes in {eq, gt, lt} order
  localparam logic [2:0] RES_EQ = 3'b100;
  localparam logic [2:0] RES_GT = 3'b010;
  localparam logic [2:0] RES_LT = 3'b001;

  // A slice answer is trusted only if it is exactly one of the three legal codes
  function automatic logic is_onehot3(input logic [2:0] code);
    return (code == RES_EQ) || (code == RES_GT) || (code == RES_LT);
  endfunction

endpackage

// File: rtl/comp.sv
// rtl/comp.sv - 2-bit digit magnitude comparator slice
module comp
  import comp_pkg::*;
(
  input  logic [3:0] data,  // {a digit, b digit}
  output logic [2:0] res    // {eq, gt, lt}
);

  // Compare the a digit (upper pair) against the b digit (lower pair)
  always_comb begin
    res = RES_EQ;
    if (data[3:2] > data[1:0]) begin
      res = RES_GT;
    end else if (data[3:2] < data[1:0]) begin
      res = RES_LT;
    end
  end

endmodule

// File: rtl/comp_seq_ctrl.sv
// rtl/comp_seq_ctrl.sv - digit-serial wide magnitude comparator controller
module comp_seq_ctrl
  import comp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             eq,
  output logic             gt,
  output logic             lt,
  output logic             err
);

  localparam int DIGITS = WIDTH / 2;
  localparam int IDXW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDXW-1:0] IDX_MAX = IDXW'(DIGITS - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [2:0]       res_q, res_d;
  logic             err_q, err_d;
  logic [2:0]       slice_res;

  comp u_slice (
    .data ({a_q[WIDTH-1 -: 2], b_q[WIDTH-1 -: 2]}),
    .res  (slice_res)
  );

  // Next-state logic: capture, walk digits MSB first, hold result until accepted
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    res_d   = res_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          idx_d   = IDX_MAX;
          res_d   = 3'b000;
          err_d   = 1'b0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (!is_onehot3(slice_res)) begin
          res_d   = 3'b000;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (slice_res != RES_EQ) begin
          res_d   = slice_res;
          state_d = S_DONE;
        end else if (idx_q == '0) begin
          res_d   = RES_EQ;
          state_d = S_DONE;
        end else begin
          a_d   = a_q << 2;
          b_d   = b_q << 2;
          idx_d = idx_q - IDXW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          res_d   = 3'b000;
          err_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      res_q   <= 3'b000;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign eq        = res_q[2];
  assign gt        = res_q[1];
  assign lt        = res_q[0];
  assign err       = err_q;

endmodule

// File: doc/comp_seq_ctrl.md
# comp_seq_ctrl

Sequential wide unsigned magnitude comparator controller. It compares two WIDTH-bit operands by feeding one 2-bit digit pair per cycle through the shared 2-bit comparator slice `comp`, most-significant digit first, and stops at the first unequal digit. It sits between an operand producer and a result consumer, with valid/ready handshakes on both sides, and is the only driver of the slice's `data` input.

## Interface
- `WIDTH`, default 8: operand width in bits. Must be even and ≥ 2. DIGITS = WIDTH/2.
- `clk`  input  1  rising-edge clock.
- `reset_n`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  operands `a`/`b` are valid.
- `in_ready`  output  1  controller can accept operands.
- `a`  input  WIDTH  left operand, unsigned.
- `b`  input  WIDTH  right operand, unsigned.
- `out_valid`  output  1  result is valid.
- `out_ready`  input  1  consumer accepts the result.
- `eq`, `gt`, `lt`  output  1 each  one-hot result of a ? b.
- `err`  output  1  slice returned a non-one-hot code.

## Operation
- FSM states: S_IDLE, S_RUN, S_DONE. Reset puts the FSM in S_IDLE.
- Reset values: `out_valid`=0, `eq`=`gt`=`lt`=0, `err`=0. `in_ready`=1 once the FSM is in S_IDLE.
- `in_ready` = (state == S_IDLE). It is decoded from the state register, so it has no combinational path from `out_ready`.
- **S_IDLE:** on `in_valid && in_ready`, capture `a` and `b` into shift registers, load digit index = DIGITS-1, and go to S_RUN. `a` and `b` are ignored in every other state.
- **S_RUN:** slice `data` = {a_sh[W-1:W-2], b_sh[W-1:W-2]}, so the upper 2 bits are the a digit.
  - Slice returns GT or LT: latch that code and go to S_DONE (early termination).
  - Slice returns EQ and index ≠ 0: shift both registers left by 2 and decrement the index.
  - Slice returns EQ and index = 0: latch EQ and go to S_DONE.
  - Slice returns anything not one-hot (000, or two or more bits set): go to S_DONE with `err`=1 and `eq`=`gt`=`lt`=0.
- **S_DONE:** `out_valid`=1. `eq`/`gt`/`lt`/`err` are held stable until `out_valid && out_ready`, then the FSM returns to S_IDLE. `err` is cleared when the result is accepted.
- Outputs `eq`/`gt`/`lt`/`err` are registered. They read 0 whenever `out_valid`=0.
- Reset mid-operation: the FSM aborts immediately and no result is produced.

## Timing
- Accept edge = E0. Digit k (k = 1..d) is compared in cycle k after E0, where d is the number of digits examined (1 ≤ d ≤ DIGITS).
- `out_valid` rises d+1 cycles after E0.
  - Best case: 2 cycles.
  - Worst case (equal operands, or a difference only in the LSB digit): DIGITS+1 cycles.
- `in_ready` drops the cycle after E0. It returns the cycle after the result-accept edge.
- Minimum issue interval: d+2 cycles. There is no back-to-back overlap of result and accept.
- A held `out_ready`=0 stalls indefinitely with no change to outputs.

## Structure
- Package `comp_pkg`:
  - `state_t` enum {S_IDLE, S_RUN, S_DONE}.
  - Result-code constants RES_EQ=3'b100, RES_GT=3'b010, RES_LT=3'b001, matching the {eq, gt, lt} order.
- One sub-module: instantiate the existing slice `comp` as `u_slice`. The controller must not re-implement the digit compare.

## Test plan
- **Reset:** assert `reset_n`=0 during S_RUN → next cycle `out_valid`=0, `eq`/`gt`/`lt`/`err`=0. After release, `in_ready`=1 and no stale result appears.
- **Early GT (WIDTH=8):** a=8'hB4, b=8'h74. MSB digits 10 vs 01 → `gt`=1, `eq`=`lt`=0, `out_valid` exactly 2 cycles after E0.
- **Full-length EQ:** a=b=8'hAA. Every digit is 10 vs 10 → `eq`=1, `err`=0, `out_valid` 5 cycles after E0. A GT result here flags a slice defect.
- **LSB-decided LT:** a=8'h12, b=8'h13 → `lt`=1 after 4 digits, `out_valid` 5 cycles after E0.
- **Backpressure:** hold `out_ready`=0 for 3 cycles with `in_valid`=1 and new operands driven → outputs stable, `in_ready`=0, and the new operands are not captured until after the accept edge.
- **Error path:** force the slice output to 3'b000 on the first digit → `err`=1, `eq`=`gt`=`lt`=0, `out_valid` 2 cycles after E0.
